// File: rtl/eq2_bist_pkg.sv
// Shared definitions for the eq2 built-in self-test sequencer:
// the FSM state encoding and the default parameter values.
package eq2_bist_defs;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int DEFAULT_WIDTH  = 2;
   localparam int DEFAULT_SETTLE = 1;

endpackage

// File: rtl/eq2_bist_vecgen.sv
// Vector index generator: holds idx, splits it into the a/b operands
// (a is the upper half) and flags the final all-ones vector.
module eq2_bist_vecgen #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             last_o
);

   localparam int IW = 2 * WIDTH;

   logic [IW-1:0] idx_q;
   logic [IW-1:0] idx_d;

   always_comb begin
      idx_d = idx_q;
      if (clr_i) begin
         idx_d = '0;
      end else if (inc_i) begin
         idx_d = idx_q + IW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign a_o    = idx_q[IW-1:WIDTH];
   assign b_o    = idx_q[WIDTH-1:0];
   assign last_o = &idx_q;

endmodule

// File: rtl/eq2_bist.sv
// BIST sequencer for the eq2 comparator: sweeps every operand pair, holds
// each for SETTLE cycles, then checks aeqb against an inline equality.
module eq2_bist
   import eq2_bist_defs::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int SETTLE = DEFAULT_SETTLE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic [WIDTH-1:0]   a_out,
   output logic [WIDTH-1:0]   b_out,
   input  logic               aeqb_in,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic               fail_valid,
   output logic [WIDTH-1:0]   first_fail_a,
   output logic [WIDTH-1:0]   first_fail_b
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int ERR_W = 2 * WIDTH + 1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   settle_q, settle_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               pass_q, pass_d;
   logic               fv_q, fv_d;
   logic [WIDTH-1:0]   ffa_q, ffa_d;
   logic [WIDTH-1:0]   ffb_q, ffb_d;
   logic               vec_clr;
   logic               vec_inc;
   logic               vec_last;
   logic               mismatch;

   eq2_bist_vecgen #(
      .WIDTH (WIDTH)
   ) u_vecgen (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (vec_clr),
      .inc_i  (vec_inc),
      .a_o    (a_out),
      .b_o    (b_out),
      .last_o (vec_last)
   );

   // Reference result is the plain operand equality, independent of any eq2.
   assign mismatch = (aeqb_in != (a_out == b_out));

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      err_d    = err_q;
      pass_d   = pass_q;
      fv_d     = fv_q;
      ffa_d    = ffa_q;
      ffb_d    = ffb_q;
      vec_clr  = 1'b0;
      vec_inc  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               vec_clr  = 1'b1;
               settle_d = '0;
               err_d    = '0;
               pass_d   = 1'b0;
               fv_d     = 1'b0;
               ffa_d    = '0;
               ffb_d    = '0;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            settle_d = settle_q + CNT_W'(1);
            if (settle_q == CNT_W'(SETTLE - 1)) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (mismatch) begin
               err_d = err_q + ERR_W'(1);
               if (!fv_q) begin
                  fv_d  = 1'b1;
                  ffa_d = a_out;
                  ffb_d = b_out;
               end
            end
            if (vec_last) begin
               state_d = ST_DONE;
            end else begin
               vec_inc  = 1'b1;
               settle_d = '0;
               state_d  = ST_SETTLE;
            end
         end
         ST_DONE: begin
            pass_d  = (err_q == '0);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         settle_q <= '0;
         err_q    <= '0;
         pass_q   <= 1'b0;
         fv_q     <= 1'b0;
         ffa_q    <= '0;
         ffb_q    <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         err_q    <= err_d;
         pass_q   <= pass_d;
         fv_q     <= fv_d;
         ffa_q    <= ffa_d;
         ffb_q    <= ffb_d;
      end
   end

   assign busy         = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
   assign done         = (state_q == ST_DONE);
   assign pass         = pass_q;
   assign err_count    = err_q;
   assign fail_valid   = fv_q;
   assign first_fail_a = ffa_q;
   assign first_fail_b = ffb_q;

endmodule

// File: tb/tb_eq2_bist.sv
// Self-checking bench for eq2_bist: behavioural comparator models (correct,
// stuck, inverted, random fault table) and a reference sweep tally.
module tb_eq2_bist;

   logic        clk = 1'b0;
   logic        reset;
   logic        start1, start3;
   logic [1:0]  a1, b1, a3, b3;
   logic        aeqb1, aeqb3;
   logic        busy1, done1, pass1, fv1;
   logic        busy3, done3, pass3, fv3;
   logic [4:0]  err1, err3;
   logic [1:0]  ffa1, ffb1, ffa3, ffb3;

   int          mode;
   logic [15:0] mask;
   int          total  = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   // Comparator model: 0 correct, 1 stuck-0, 2 stuck-1, 3 inverted, 4 fault table
   function automatic logic cmp_model(input int m, input logic [1:0] a, input logic [1:0] b,
                                      input logic [15:0] mk);
      logic [3:0] k;
      k = {a, b};
      case (m)
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return !(a == b);
         4:       return (a == b) ^ mk[k];
         default: return (a == b);
      endcase
   endfunction

   assign aeqb1 = cmp_model(mode, a1, b1, mask);
   assign aeqb3 = (a3 == b3);

   eq2_bist dut (
      .clk(clk), .reset(reset), .start(start1), .a_out(a1), .b_out(b1), .aeqb_in(aeqb1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_valid(fv1),
      .first_fail_a(ffa1), .first_fail_b(ffb1)
   );

   eq2_bist #(.WIDTH(2), .SETTLE(3)) dut_s3 (
      .clk(clk), .reset(reset), .start(start3), .a_out(a3), .b_out(b3), .aeqb_in(aeqb3),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_valid(fv3),
      .first_fail_a(ffa3), .first_fail_b(ffb3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Pulses start on the selected DUT and follows the sweep to its done pulse.
   // lat: negedges from acceptance to done; runs/bad: completed operand holds
   // and how many of them differ from the hold length.
   task automatic run_sweep(input int sel, input bit repulse, input int hold,
                            output int lat, output int busy_n, output int runs, output int bad);
      int  n;
      int  run_len;
      bit  seen;
      logic [3:0] prev, cur;
      lat = -1; busy_n = 0; runs = 0; bad = 0; seen = 1'b0; n = 0; run_len = 0;
      if (sel == 0) start1 = 1'b1; else start3 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
      prev = (sel == 0) ? {a1, b1} : {a3, b3};
      while (!seen && n < 200) begin
         if (repulse) start1 = (n == 10);
         cur = (sel == 0) ? {a1, b1} : {a3, b3};
         if (cur != prev) begin
            runs++;
            if (run_len != hold) bad++;
            run_len = 0;
            prev = cur;
         end
         run_len++;
         busy_n += (sel == 0) ? int'(busy1) : int'(busy3);
         if ((sel == 0) ? done1 : done3) begin
            seen = 1'b1;
            lat  = n;
         end else begin
            @(negedge clk);
            n++;
         end
      end
      start1 = 1'b0;
      check("sweep_timeout", 32'(seen), 32'd1);
      @(negedge clk);
      check("done_single", 32'((sel == 0) ? done1 : done3), 32'd0);
   endtask

   initial begin
      int lat, bn, runs, bad, n, exp_err, exp_ffa, exp_ffb, done_seen;
      bit exp_fv, found;
      reset = 1'b1; start1 = 1'b0; start3 = 1'b0; mode = 0; mask = '0;
      @(negedge clk); @(negedge clk);
      check("rst_a", 32'(a1), 0);        check("rst_b", 32'(b1), 0);
      check("rst_busy", 32'(busy1), 0);  check("rst_done", 32'(done1), 0);
      check("rst_pass", 32'(pass1), 0);  check("rst_err", 32'(err1), 0);
      check("rst_fv", 32'(fv1), 0);      check("rst_ff", 32'({ffa1, ffb1}), 0);
      reset = 1'b0;
      @(negedge clk);

      // Correct comparator
      mode = 0;
      run_sweep(0, 1'b0, 2, lat, bn, runs, bad);
      $display("sweep correct: lat=%0d busy=%0d err=%0d pass=%0d", lat, bn, err1, pass1);
      check("ok_lat", 32'(lat), 32);     check("ok_busy", 32'(bn), 32);
      check("ok_err", 32'(err1), 0);     check("ok_pass", 32'(pass1), 1);
      check("ok_fv", 32'(fv1), 0);
      check("ok_runs", 32'(runs), 15);   check("ok_hold", 32'(bad), 0);

      // Stuck at 0
      mode = 1;
      run_sweep(0, 1'b0, 2, lat, bn, runs, bad);
      $display("sweep stuck0: err=%0d pass=%0d ff=%0d,%0d", err1, pass1, ffa1, ffb1);
      check("s0_err", 32'(err1), 4);     check("s0_pass", 32'(pass1), 0);
      check("s0_fv", 32'(fv1), 1);       check("s0_ffa", 32'(ffa1), 0);
      check("s0_ffb", 32'(ffb1), 0);

      // Stuck at 1
      mode = 2;
      run_sweep(0, 1'b0, 2, lat, bn, runs, bad);
      $display("sweep stuck1: err=%0d ff=%0d,%0d", err1, ffa1, ffb1);
      check("s1_err", 32'(err1), 12);    check("s1_ffa", 32'(ffa1), 0);
      check("s1_ffb", 32'(ffb1), 1);     check("s1_pass", 32'(pass1), 0);

      // Inverted
      mode = 3;
      run_sweep(0, 1'b0, 2, lat, bn, runs, bad);
      $display("sweep inverted: err=%0d", err1);
      check("inv_err", 32'(err1), 16);

      // SETTLE=3 instance with a correct comparator
      run_sweep(1, 1'b0, 4, lat, bn, runs, bad);
      $display("sweep settle3: lat=%0d busy=%0d runs=%0d bad=%0d pass=%0d", lat, bn, runs, bad, pass3);
      check("s3_lat", 32'(lat), 64);     check("s3_busy", 32'(bn), 64);
      check("s3_runs", 32'(runs), 15);   check("s3_hold", 32'(bad), 0);
      check("s3_pass", 32'(pass3), 1);   check("s3_err", 32'(err3), 0);

      // Start re-pulsed while busy
      mode = 0;
      run_sweep(0, 1'b1, 2, lat, bn, runs, bad);
      $display("sweep repulse: lat=%0d busy=%0d", lat, bn);
      check("rp_lat", 32'(lat), 32);     check("rp_busy", 32'(bn), 32);
      check("rp_idle", 32'(busy1), 0);

      // Start held high continuously
      mode = 1;
      start1 = 1'b1;
      @(negedge clk);
      n = 0;
      while (!done1 && n < 100) begin @(negedge clk); n++; end
      check("hold_done1", 32'(done1), 1);
      check("hold_err1", 32'(err1), 4);
      @(negedge clk);
      check("hold_idle", 32'(busy1), 0);
      @(negedge clk);
      check("hold_busy", 32'(busy1), 1);
      check("hold_clr", 32'(err1), 0);
      n = 0;
      while (!done1 && n < 100) begin @(negedge clk); n++; end
      $display("sweep held-start: second done after %0d, err=%0d", n, err1);
      check("hold_lat2", 32'(n), 32);
      check("hold_err2", 32'(err1), 4);
      start1 = 1'b0;
      @(negedge clk); @(negedge clk);

      // Random fault tables against a tally computed pair by pair
      mode = 4;
      for (int t = 0; t < 4; t++) begin
         mask = 16'($urandom);
         if (t == 0) mask = 16'h0;
         exp_err = 0; exp_fv = 1'b0; exp_ffa = 0; exp_ffb = 0;
         for (int av = 0; av < 4; av++) begin
            for (int bv = 0; bv < 4; bv++) begin
               if (cmp_model(4, 2'(av), 2'(bv), mask) != (av == bv)) begin
                  exp_err++;
                  if (!exp_fv) begin exp_fv = 1'b1; exp_ffa = av; exp_ffb = bv; end
               end
            end
         end
         run_sweep(0, 1'b0, 2, lat, bn, runs, bad);
         $display("sweep random mask=%04h: err=%0d/%0d ff=%0d,%0d", mask, err1, exp_err, ffa1, ffb1);
         check("rnd_err", 32'(err1), 32'(exp_err));
         check("rnd_pass", 32'(pass1), 32'(exp_err == 0));
         check("rnd_fv", 32'(fv1), 32'(exp_fv));
         check("rnd_ff", 32'({ffa1, ffb1}), 32'({2'(exp_ffa), 2'(exp_ffb)}));
      end

      // Asynchronous reset mid-sweep at idx=5
      mode = 1;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      found = 1'b0; n = 0;
      while (!found && n < 50) begin
         if (a1 == 2'd1 && b1 == 2'd1) found = 1'b1;
         else begin @(negedge clk); n++; end
      end
      check("ab_idx5_reached", 32'(found), 1);
      check("pre_rst_err", 32'(err1), 1);
      #2 reset = 1'b1;
      #1;
      $display("reset mid-sweep: a=%0d b=%0d busy=%0d err=%0d fv=%0d", a1, b1, busy1, err1, fv1);
      check("ar_ab", 32'({a1, b1}), 0);  check("ar_busy", 32'(busy1), 0);
      check("ar_done", 32'(done1), 0);   check("ar_err", 32'(err1), 0);
      check("ar_fv", 32'(fv1), 0);       check("ar_pass", 32'(pass1), 0);
      @(negedge clk);
      reset = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done1) done_seen++;
      end
      check("ar_no_done", 32'(done_seen), 0);
      mode = 0;
      run_sweep(0, 1'b0, 2, lat, bn, runs, bad);
      $display("sweep after reset: lat=%0d pass=%0d", lat, pass1);
      check("ar_lat", 32'(lat), 32);     check("ar_pass_after", 32'(pass1), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/eq2_bist.md
# eq2_bist

Synthesizable built-in self-test sequencer for the `eq2` 2-bit equality comparator. It drives every (a, b) operand pair into a comparator instance and samples the comparator's `aeqb` result. It checks that result against its own expected value, counts mismatches and records the first failing pair. It sits beside `eq2` on the board top level and does in hardware what the simulation bench does with delays.

## Interface
Parameters:
- `WIDTH`, 2: operand width; sweep covers 2^(2·WIDTH) pairs.
- `SETTLE`, 1: cycles each pair is held before sampling; legal range ≥ 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: request a sweep; sampled only in IDLE.
- `a_out` out WIDTH: operand a to the comparator (`a`).
- `b_out` out WIDTH: operand b to the comparator (`b`).
- `aeqb_in` in 1: comparator result (`aeqb`).
- `busy` out 1: high from start acceptance until DONE is entered.
- `done` out 1: one-cycle pulse at end of sweep.
- `pass` out 1: 1 if err_count==0 at end of sweep; held until next start.
- `err_count` out 2·WIDTH+1: mismatches in the last or current sweep.
- `fail_valid` out 1: first_fail_* holds a captured pair.
- `first_fail_a` out WIDTH: a of the first mismatching pair.
- `first_fail_b` out WIDTH: b of the first mismatching pair.

## Operation
- Vector index `idx` has width 2·WIDTH. `a_out = idx[2W-1:W]` and `b_out = idx[W-1:0]`, both driven directly from registers.
- The expected result is `(a_out == b_out)`, computed inline. It must not come from an `eq2` instance.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE with `start`=1: idx←0, settle_cnt←0, err_count←0, pass←0, fail_valid←0, first_fail_*←0, then → SETTLE.
  - SETTLE: settle_cnt increments each cycle. When settle_cnt==SETTLE-1, go → CHECK.
  - CHECK: sample `aeqb_in`. On mismatch, err_count increments. If fail_valid==0, capture first_fail_a/b and set fail_valid. Then:
    - if idx is all-ones, → DONE;
    - otherwise idx increments, settle_cnt←0, → SETTLE.
  - DONE: `done`=1 and pass←(err_count==0, including the final CHECK's update), then → IDLE.
- `busy` is high in SETTLE and CHECK.
- `start` is ignored in SETTLE, CHECK and DONE; nothing is queued.
- err_count cannot overflow, since its maximum is 2^(2W).
- Reset while a sweep is running aborts it. All outputs return to reset values, the FSM goes to IDLE and no `done` is emitted.

## Timing
- Reset values:
  - a_out=0, b_out=0
  - busy=0, done=0, pass=0
  - err_count=0, fail_valid=0, first_fail_a=0, first_fail_b=0
- Start accepted at edge k. Vector i is sampled at edge k+(SETTLE+1)(i+1).
- DONE is entered at edge k+(SETTLE+1)·2^(2W), so `done` is high in the following cycle. With the defaults this is edge k+32 and done is high for exactly one cycle.
- Each pair is stable on a_out/b_out for SETTLE+1 cycles before and including its sample edge.
- The earliest a new start can be accepted is the cycle after DONE, back in IDLE.

## Structure
- Shared package or header `eq2_bist_defs` holds the state encoding localparams (IDLE=2'd0, SETTLE=2'd1, CHECK=2'd2, DONE=2'd3) and the default WIDTH/SETTLE values.
- One sub-module, `eq2_bist_vecgen`, contains the idx register with clear/increment/last flag and the a/b split.
- The FSM, settle counter and result registers live in `eq2_bist`.

## Test plan
Each scenario below instantiates a comparator model in the bench.
- Correct `eq2`, default parameters, start pulse: busy for 32 cycles, done pulses once, pass=1, err_count=0, fail_valid=0.
- `aeqb` stuck at 0: err_count=4, pass=0, first_fail_a=0, first_fail_b=0.
- `aeqb` stuck at 1: err_count=12, first_fail_a=0, first_fail_b=1.
- Inverted comparator: err_count=16. Separately, with SETTLE=3 and a correct comparator, done arrives 64 cycles after start acceptance and each pair is held 4 cycles.
- Start re-pulsed while busy: ignored, sweep length unchanged. Start held high continuously: a new sweep begins the cycle after each done, and err_count clears at each acceptance.
- Reset asserted mid-sweep (e.g. at idx=5, asynchronous, between edges): all outputs are immediately at reset values and no done is emitted. A following start then runs a full 32-cycle sweep with pass=1.
